// File: rtl/io_mmio_ctrl.sv
// rtl/io_mmio_ctrl.sv - memory-mapped switch/button/LED controller with debounce and status flags
module io_mmio_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3,
  parameter int SW_WIDTH  = 16,
  parameter int LED_WIDTH = 12,
  parameter int DB_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pRead,
  input  logic                 pWrite,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    pWriteData,
  output logic [DATA_W-1:0]    pReadData,
  input  logic                 buttonL,
  input  logic                 buttonR,
  input  logic [SW_WIDTH-1:0]  switch,
  output logic [LED_WIDTH-1:0] led,
  output logic                 irq
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  localparam logic [ADDR_W-1:0] A_STATUS     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_LED_DATA   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SW_DATA    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_SW_LIVE    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CTRL       = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_STATUS_CLR = ADDR_W'(5);

  // index 0 is buttonL, index 1 is buttonR
  logic [1:0]       btn_raw;
  logic [1:0]       btn_s1;
  logic [1:0]       btn_s2;
  logic [1:0]       btn_db;
  logic [1:0]       btn_db_next;
  logic [1:0]       btn_press;
  logic [CNT_W-1:0] btn_cnt [2];

  logic [SW_WIDTH-1:0]  sw_s1;
  logic [SW_WIDTH-1:0]  sw_s2;
  logic [SW_WIDTH-1:0]  snapshot;
  logic [LED_WIDTH-1:0] shadow;
  logic [3:0]           ctrl;

  logic led_ack;
  logic sw_valid;
  logic sw_ovr;
  logic led_ack_next;
  logic sw_valid_next;
  logic sw_ovr_next;

  logic press_l;
  logic press_r;
  logic wr_led;
  logic wr_ctrl;
  logic wr_clr;
  logic rd_sw;
  logic sw_clear;
  logic capture;
  logic auto_led;
  logic auto_sw;
  logic ie_led;
  logic ie_sw;
  logic unused_wdata;

  assign btn_raw  = {buttonR, buttonL};
  assign press_l  = btn_press[0];
  assign press_r  = btn_press[1];
  assign auto_led = ctrl[0];
  assign auto_sw  = ctrl[1];
  assign ie_led   = ctrl[2];
  assign ie_sw    = ctrl[3];

  assign wr_led  = pWrite && (addr == A_LED_DATA);
  assign wr_ctrl = pWrite && (addr == A_CTRL);
  assign wr_clr  = pWrite && (addr == A_STATUS_CLR);
  assign rd_sw   = pRead  && (addr == A_SW_DATA);
  assign capture = press_r || auto_sw;

  assign unused_wdata = ^pWriteData;

  // The debounced level flips only after DB_CYCLES consecutive disagreeing samples
  always_comb begin
    btn_db_next = btn_db;
    for (int i = 0; i < 2; i++) begin
      if ((btn_s2[i] != btn_db[i]) && (btn_cnt[i] == CNT_LAST)) begin
        btn_db_next[i] = btn_s2[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1     <= '0;
      btn_s2     <= '0;
      btn_db     <= '0;
      btn_press  <= '0;
      btn_cnt[0] <= '0;
      btn_cnt[1] <= '0;
      sw_s1      <= '0;
      sw_s2      <= '0;
    end else begin
      btn_s1    <= btn_raw;
      btn_s2    <= btn_s1;
      btn_db    <= btn_db_next;
      btn_press <= btn_db_next & ~btn_db;
      sw_s1     <= switch;
      sw_s2     <= sw_s1;
      for (int i = 0; i < 2; i++) begin
        if ((btn_s2[i] == btn_db[i]) || (btn_cnt[i] == CNT_LAST)) begin
          btn_cnt[i] <= '0;
        end else begin
          btn_cnt[i] <= btn_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Set events beat STATUS_CLR; an LED_DATA write beats a same-cycle L press
  always_comb begin
    sw_clear = rd_sw || (wr_clr && pWriteData[1]);

    led_ack_next = led_ack;
    if (wr_led) begin
      led_ack_next = 1'b0;
    end else if (press_l) begin
      led_ack_next = 1'b1;
    end else if (wr_clr && pWriteData[0]) begin
      led_ack_next = 1'b0;
    end

    sw_valid_next = sw_valid;
    if (press_r) begin
      sw_valid_next = 1'b1;
    end else if (sw_clear) begin
      sw_valid_next = 1'b0;
    end

    sw_ovr_next = sw_ovr;
    if (press_r && sw_valid && !sw_clear) begin
      sw_ovr_next = 1'b1;
    end else if (wr_clr && pWriteData[2]) begin
      sw_ovr_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led      <= '0;
      shadow   <= '0;
      snapshot <= '0;
      ctrl     <= '0;
      led_ack  <= 1'b0;
      sw_valid <= 1'b0;
      sw_ovr   <= 1'b0;
    end else begin
      if (wr_led) begin
        shadow <= pWriteData[LED_WIDTH-1:0];
      end
      if (wr_led && auto_led) begin
        led <= pWriteData[LED_WIDTH-1:0];
      end else if (press_l) begin
        led <= shadow;
      end
      if (wr_ctrl) begin
        ctrl <= pWriteData[3:0];
      end
      if (capture) begin
        snapshot <= sw_s2;
      end
      led_ack  <= led_ack_next;
      sw_valid <= sw_valid_next;
      sw_ovr   <= sw_ovr_next;
    end
  end

  always_comb begin
    pReadData = '0;
    if (pRead) begin
      case (addr)
        A_STATUS:   pReadData = DATA_W'({sw_ovr, sw_valid, led_ack});
        A_LED_DATA: pReadData = DATA_W'(shadow);
        A_SW_DATA:  pReadData = DATA_W'(snapshot);
        A_SW_LIVE:  pReadData = DATA_W'(sw_s2);
        A_CTRL:     pReadData = DATA_W'(ctrl);
        default:    pReadData = '0;
      endcase
    end
  end

  assign irq = (led_ack && ie_led) || (sw_valid && ie_sw);

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// tb/tb_io_mmio_ctrl.sv - self-checking bench for io_mmio_ctrl
module tb_io_mmio_ctrl;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pRead;
  logic        pWrite;
  logic [2:0]  addr;
  logic [31:0] pWriteData;
  logic [31:0] pReadData;
  logic        buttonL;
  logic        buttonR;
  logic [15:0] switch;
  logic [11:0] led;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;

  io_mmio_ctrl #(
    .DATA_W(32), .ADDR_W(3), .SW_WIDTH(16), .LED_WIDTH(12), .DB_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .pRead(pRead), .pWrite(pWrite), .addr(addr),
    .pWriteData(pWriteData), .pReadData(pReadData), .buttonL(buttonL),
    .buttonR(buttonR), .switch(switch), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[20];

  // reference model state
  logic [11:0] m_shadow, m_led;
  logic [15:0] m_snap, sw_h0, sw_h1;
  logic [3:0]  m_ctrl;
  logic        m_ack, m_valid, m_ovr;
  logic [1:0]  m_db, m_press;
  logic [7:0]  m_hist [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [2:0] a, output logic [31:0] v);
    pRead = 1'b1;
    addr  = a;
    #1;
    v = pReadData;
    pRead = 1'b0;
  endtask

  task automatic peek_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] v;
    peek(a, v);
    check(name, v, exp);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    pWrite = 1'b1;
    addr = a;
    pWriteData = d;
    step();
    pWrite = 1'b0;
  endtask

  task automatic press(input int which);
    if (which == 0) buttonL = 1'b1; else buttonR = 1'b1;
    repeat (8) step();
    buttonL = 1'b0;
    buttonR = 1'b0;
    repeat (12) step();
  endtask

  task automatic model_reset();
    m_shadow = '0; m_led = '0; m_snap = '0; sw_h0 = '0; sw_h1 = '0;
    m_ctrl = '0; m_ack = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
    m_db = '0; m_press = '0; m_hist[0] = '0; m_hist[1] = '0;
  endtask

  function automatic logic [31:0] model_read();
    if (!pRead) return 32'h0;
    case (addr)
      3'd0: return {29'h0, m_ovr, m_valid, m_ack};
      3'd1: return {20'h0, m_shadow};
      3'd2: return {16'h0, m_snap};
      3'd3: return {16'h0, sw_h1};
      3'd4: return {28'h0, m_ctrl};
      default: return 32'h0;
    endcase
  endfunction

  // advances the model across one rising edge using the inputs currently driven
  task automatic model_step();
    logic wr_led, wr_ctrl, wr_clr, rd_sw, pl, pr, clearing, diff;
    logic [1:0] raw, new_db;
    logic [11:0] n_led;
    wr_led  = pWrite && addr == 3'd1;
    wr_ctrl = pWrite && addr == 3'd4;
    wr_clr  = pWrite && addr == 3'd5;
    rd_sw   = pRead  && addr == 3'd2;
    pl = m_press[0];
    pr = m_press[1];
    clearing = rd_sw || (wr_clr && pWriteData[1]);

    n_led = m_led;
    if (wr_led && m_ctrl[0]) n_led = pWriteData[11:0];
    else if (pl) n_led = m_shadow;
    m_led = n_led;
    if (wr_led) m_shadow = pWriteData[11:0];

    if (wr_led) m_ack = 1'b0;
    else if (pl) m_ack = 1'b1;
    else if (wr_clr && pWriteData[0]) m_ack = 1'b0;

    if (pr && m_valid && !clearing) m_ovr = 1'b1;
    else if (wr_clr && pWriteData[2]) m_ovr = 1'b0;
    if (pr) m_valid = 1'b1;
    else if (clearing) m_valid = 1'b0;

    if (pr || m_ctrl[1]) m_snap = sw_h1;
    if (wr_ctrl) m_ctrl = pWriteData[3:0];

    // a level change needs the last DB synchronised samples (raw delayed two edges) all to disagree
    raw = {buttonR, buttonL};
    for (int b = 0; b < 2; b++) begin
      diff = 1'b1;
      for (int k = 1; k <= DB; k++) if (m_hist[b][k] == m_db[b]) diff = 1'b0;
      new_db[b] = diff ? ~m_db[b] : m_db[b];
      m_press[b] = new_db[b] & ~m_db[b];
      m_hist[b] = {m_hist[b][6:0], raw[b]};
    end
    m_db = new_db;
    sw_h1 = sw_h0;
    sw_h0 = switch;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int rem[2];
    logic lvl[2];
    int r;

    reset = 1'b0; pRead = 1'b0; pWrite = 1'b0; addr = '0; pWriteData = '0;
    buttonL = 1'b0; buttonR = 1'b0; switch = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_led", 32'(led), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    reset = 1'b1;
    step();

    vt[0]  = '{1'b0, 3'd0, 32'h0, 32'h0};
    vt[1]  = '{1'b0, 3'd1, 32'h0, 32'h0};
    vt[2]  = '{1'b0, 3'd2, 32'h0, 32'h0};
    vt[3]  = '{1'b0, 3'd3, 32'h0, 32'h0};
    vt[4]  = '{1'b0, 3'd4, 32'h0, 32'h0};
    vt[5]  = '{1'b0, 3'd5, 32'h0, 32'h0};
    vt[6]  = '{1'b0, 3'd6, 32'h0, 32'h0};
    vt[7]  = '{1'b0, 3'd7, 32'h0, 32'h0};
    vt[8]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0};
    vt[9]  = '{1'b0, 3'd1, 32'h0, 32'h0000_0FFF};
    vt[10] = '{1'b1, 3'd4, 32'hFFFF_FFFF, 32'h0};
    vt[11] = '{1'b0, 3'd4, 32'h0, 32'h0000_000F};
    vt[12] = '{1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0};
    vt[13] = '{1'b0, 3'd6, 32'h0, 32'h0};
    vt[14] = '{1'b1, 3'd7, 32'h1234_5678, 32'h0};
    vt[15] = '{1'b0, 3'd7, 32'h0, 32'h0};
    vt[16] = '{1'b0, 3'd5, 32'h0, 32'h0};
    vt[17] = '{1'b1, 3'd4, 32'h0, 32'h0};
    vt[18] = '{1'b0, 3'd4, 32'h0, 32'h0};
    vt[19] = '{1'b0, 3'd0, 32'h0, 32'h0};

    for (int i = 0; i < 20; i++) begin
      if (vt[i].wr) begin
        bus_write(vt[i].a, vt[i].d);
      end else begin
        peek(vt[i].a, v);
        check($sformatf("vec%0d", i), v, vt[i].exp);
        step();
      end
    end
    check("led_untouched", 32'(led), 32'h0);

    // L press latency: effect lands at edge 3+DB after the first sample
    bus_write(3'd1, 32'hABC);
    buttonL = 1'b1;
    repeat (2 + DB) step();
    check("l_before_edge7", 32'(led), 32'h0);
    step();
    check("l_edge7", 32'(led), 32'hABC);
    peek_check("l_status", 3'd0, 32'h1);
    bus_write(3'd1, 32'h123);
    repeat (2) step();
    buttonL = 1'b0;
    repeat (12) step();
    check("l_no_repeat", 32'(led), 32'hABC);
    peek_check("l_ack_cleared", 3'd0, 32'h0);

    // glitch shorter than DB samples
    buttonL = 1'b1;
    repeat (DB - 1) step();
    buttonL = 1'b0;
    repeat (12) step();
    check("glitch_led", 32'(led), 32'hABC);
    peek_check("glitch_status", 3'd0, 32'h0);

    // switch capture, valid, overrun, clear
    switch = 16'h1234;
    repeat (3) step();
    press(1);
    peek_check("r_status", 3'd0, 32'h2);
    peek_check("r_swdata", 3'd2, 32'h1234);
    step();
    pRead = 1'b1; addr = 3'd2;
    #1;
    check("r_read", pReadData, 32'h1234);
    step();
    pRead = 1'b0;
    peek_check("r_valid_cleared", 3'd0, 32'h0);
    press(1);
    press(1);
    peek_check("r_overrun", 3'd0, 32'h6);
    bus_write(3'd5, 32'h4);
    peek_check("r_clr_ovr", 3'd0, 32'h2);
    bus_write(3'd5, 32'h2);
    peek_check("r_clr_valid", 3'd0, 32'h0);

    // LED_DATA write in the press-pulse cycle
    bus_write(3'd1, 32'h111);
    buttonL = 1'b1;
    repeat (2 + DB) step();
    pWrite = 1'b1; addr = 3'd1; pWriteData = 32'h222;
    step();
    pWrite = 1'b0;
    check("conflict_led", 32'(led), 32'h111);
    peek_check("conflict_shadow", 3'd1, 32'h222);
    peek_check("conflict_ack", 3'd0, 32'h0);
    buttonL = 1'b0;
    repeat (12) step();
    bus_write(3'd4, 32'h1);
    bus_write(3'd1, 32'h5A5);
    check("auto_led", 32'(led), 32'h5A5);
    bus_write(3'd4, 32'h0);

    // interrupt from SW_VALID
    bus_write(3'd4, 32'h8);
    check("irq_idle", 32'(irq), 32'h0);
    press(1);
    check("irq_set", 32'(irq), 32'h1);
    pRead = 1'b1; addr = 3'd2;
    #1;
    check("irq_read_data", pReadData, 32'h1234);
    check("irq_still_high", 32'(irq), 32'h1);
    step();
    pRead = 1'b0;
    check("irq_cleared", 32'(irq), 32'h0);

    // reset mid-operation and mid-debounce
    bus_write(3'd4, 32'h5);
    bus_write(3'd1, 32'h7FF);
    check("pre_reset_led", 32'(led), 32'h7FF);
    press(0);
    check("pre_reset_irq", 32'(irq), 32'h1);
    buttonR = 1'b1;
    repeat (4) step();
    reset = 1'b0;
    #1;
    check("async_led", 32'(led), 32'h0);
    check("async_irq", 32'(irq), 32'h0);
    peek_check("async_status", 3'd0, 32'h0);
    peek_check("async_shadow", 3'd1, 32'h0);
    peek_check("async_ctrl", 3'd4, 32'h0);
    reset = 1'b1;
    repeat (2) step();
    buttonR = 1'b0;
    repeat (12) step();
    peek_check("debounce_discarded", 3'd0, 32'h0);

    // randomized run against the reference model
    reset = 1'b0;
    step();
    reset = 1'b1;
    model_reset();
    rem[0] = 0; rem[1] = 0; lvl[0] = 1'b0; lvl[1] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = 1'($urandom_range(0, 1));
          rem[b] = $urandom_range(1, 9);
        end
        rem[b]--;
      end
      buttonL = lvl[0];
      buttonR = lvl[1];
      if ($urandom_range(0, 3) == 0) switch = 16'($urandom);
      r = $urandom_range(0, 3);
      pRead  = r[0];
      pWrite = r[1];
      addr = 3'($urandom_range(0, 7));
      pWriteData = $urandom;
      #1;
      check("rnd_rdata", pReadData, model_read());
      check("rnd_led", 32'(led), 32'(m_led));
      check("rnd_irq", 32'(irq), 32'((m_ack & m_ctrl[2]) | (m_valid & m_ctrl[3])));
      @(posedge clk);
      model_step();
      #1;
    end
    pRead = 1'b0;
    pWrite = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/io_mmio_ctrl.md
Name: io_mmio_ctrl

Overview:
Parametrised memory-mapped I/O controller between the CPU data bus and the board switches, buttons and LEDs. Adds the following:
- synchronisers and counter debounce on both buttons, with single-pulse press events;
- a captured switch snapshot with valid and overrun flags;
- a shadowed LED register;
- auto modes, write-1-to-clear status and a level interrupt.

The CPU accesses it through pRead/pWrite with a word address.

Parameters:
DATA_W, 32, CPU data width
ADDR_W, 3, register address width
SW_WIDTH, 16, switch count (1..DATA_W)
LED_WIDTH, 12, LED count (1..DATA_W)
DB_CYCLES, 4, consecutive stable synchronised samples before the debounced level changes (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset; one clock; reset is asynchronous and active-low (asserted when 0)
pRead  in  1  CPU read strobe
pWrite  in  1  CPU write strobe
addr  in  ADDR_W  register address
pWriteData  in  DATA_W  write data
pReadData  out  DATA_W  read data; combinational
buttonL  in  1  raw button: commit LED shadow to LEDs
buttonR  in  1  raw button: capture switch snapshot
switch  in  SW_WIDTH  raw switches
led  out  LED_WIDTH  registered LED drive
irq  out  1  level interrupt

Behaviour:
Register map (reads return 0 unless pRead=1):
- 0 STATUS, RO: bit0 LED_ACK, bit1 SW_VALID, bit2 SW_OVR; other bits 0.
- 1 LED_DATA, RW: shadow, zero-extended on read; write takes pWriteData[LED_WIDTH-1:0].
- 2 SW_DATA, RO: snapshot, zero-extended. A read (pRead & addr==2) clears SW_VALID at the next edge.
- 3 SW_LIVE, RO: synchronised live switches.
- 4 CTRL, RW: bit0 AUTO_LED, bit1 AUTO_SW, bit2 IE_LED, bit3 IE_SW.
- 5 STATUS_CLR, WO: writing 1 clears the matching STATUS bit; reads as 0.
- 6, 7: reads 0, writes ignored.
- pRead and pWrite asserted in the same cycle: both take effect.

Reset (reset=0, asynchronous):
- led, shadow, snapshot, CTRL, STATUS, synchronisers, debounce counters, debounced levels and press pulses all go to 0.
- irq=0.
- Reset mid-debounce discards all in-progress counts.

Synchronise:
- Both buttons and switch pass through 2-flop synchronisers (s1, s2).

Debounce (per button):
- s2 == db: cnt <= 0.
- s2 != db and cnt == DB_CYCLES-1: db <= s2, cnt <= 0.
- Otherwise: cnt++.
- Press pulse is registered: press <= db_next & ~db. It is high for exactly one cycle per debounced rising edge.
- Release edges produce no event.
- Latency, button held high from the first edge that samples it (edge 1): db rises at edge 2+DB_CYCLES; press is high after that edge; its effect lands at edge 3+DB_CYCLES.
- A high glitch shorter than DB_CYCLES synchronised samples produces no event.

LED path:
- L press: led <= shadow; LED_ACK <= 1.
- LED_DATA write: shadow updates and LED_ACK <= 0.
- AUTO_LED=1: the LED_DATA write also sets led <= written value at the same edge.
- LED_DATA write and L press in the same cycle: led gets the old shadow, shadow gets new data, LED_ACK ends 0 (write wins).

Switch path:
- R press, or every cycle when AUTO_SW=1: snapshot <= s2-synchronised switches.
- A press-triggered capture sets SW_VALID. AUTO_SW captures never touch the flags.
- Capture while SW_VALID=1 and not being cleared that cycle: SW_OVR <= 1.
- SW_DATA read and capture in the same cycle: read returns the old snapshot, SW_VALID stays 1, SW_OVR unchanged.

Flag precedence:
- A set event beats a STATUS_CLR clear in the same cycle.

irq:
- irq = (LED_ACK & IE_LED) | (SW_VALID & IE_SW).
- Combinational from registers; no glitch from the bus inputs.

Test Plan:
1. Reset, then read every address -> all 0; led=0; irq=0. Assert reset mid-operation -> immediately all 0.
2. Write LED_DATA=0xABC, hold buttonL high 10 cycles (DB_CYCLES=4) -> led=0xABC exactly at edge 7 after the first sample; STATUS=0x1; no second update while still held.
3. buttonL high for 3 cycles then low -> led unchanged, STATUS=0.
4. switch=0x1234, press R -> STATUS bit1=1, SW_DATA=0x1234, STATUS bit1=0 after the read. Two presses without a read -> STATUS=0x6. Write STATUS_CLR=0x4 -> STATUS=0x2.
5. Shadow=0x111, then write 0x222 in the press-pulse cycle -> led=0x111, shadow=0x222, LED_ACK=0. With CTRL=0x1, write 0x5A5 -> led=0x5A5 the next edge.
6. CTRL=0x8, press R -> irq=1. Read SW_DATA -> irq=0 the next cycle. Reads of addresses 6 and 7 -> 0.
